// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Request/response bundle between the EX stage and the multi-cycle
// multiply/divide sequencer.
//   start  : request pulse, only honoured while the sequencer is idle
//   op     : 0 = MULTU, 1 = DIVU, sampled with start
//   src_a  : multiplicand / dividend, sampled with start
//   src_b  : multiplier / divisor, sampled with start
//   busy   : sequencer is working or presenting its result
//   done   : one-cycle pulse when hi/lo hold the final result
//   hi, lo : MULTU product high/low word, DIVU remainder/quotient
// The slave modport is the sequencer's view; the master modport is the core's view.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Multi-cycle 32x32 unsigned multiply (shift-add) and unsigned divide
// (restoring) that borrows an external combinational ALU for one
// add/subtract per cycle. The core stalls while busy is high and picks up
// hi/lo when done pulses.
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   bus          : muldiv_seq_if slave (start/op/src_a/src_b in,
//                  busy/done/hi/lo out)
//   alu_A, alu_B : operands driven to the shared ALU
//   alu_ALUop    : ALU function (0010 = ADD, 1010 = SUB)
//   alu_Result   : ALU result
//   alu_CarryOut : carry on ADD, borrow (A < B unsigned) on SUB
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_seq_if.slave      bus,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_ALUop,
    input  logic [WIDTH-1:0] alu_Result,
    input  logic             alu_CarryOut
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam int         CW      = $clog2(ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic             op_div;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] shifted;
    logic             msb_out;
    logic             q_bit;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Divide step: the partial remainder shifts left by one pulling in the
    // next dividend bit from the top of lo. A bit falling out of hi means the
    // true remainder is >= 2^32 and therefore always >= the divisor, so the
    // subtraction is taken regardless of the ALU borrow.
    assign shifted = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
    assign msb_out = hi_r[WIDTH-1];
    assign q_bit   = msb_out | ~alu_CarryOut;

    // The ALU is only ours while running; otherwise present a harmless ADD of zeros.
    always_comb begin
        alu_A     = '0;
        alu_B     = '0;
        alu_ALUop = ALU_ADD;
        if (state == RUN) begin
            alu_B = operand;
            if (op_div) begin
                alu_A     = shifted;
                alu_ALUop = ALU_SUB;
            end else begin
                alu_A     = hi_r;
                alu_ALUop = ALU_ADD;
            end
        end
    end

    // Sequencer FSM and datapath. operand holds the multiplicand for MULTU
    // and the divisor for DIVU; lo starts as the multiplier or the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            op_div  <= 1'b0;
            operand <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_div  <= bus.op;
                        operand <= bus.op ? bus.src_b : bus.src_a;
                        hi_r    <= '0;
                        lo_r    <= bus.op ? bus.src_a : bus.src_b;
                        counter <= '0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    counter <= counter + 1'b1;
                    if (op_div) begin
                        hi_r <= q_bit ? alu_Result : shifted;
                        lo_r <= {lo_r[WIDTH-2:0], q_bit};
                    end else if (lo_r[0]) begin
                        // Keep the ALU carry as bit 64 of the accumulator before shifting.
                        hi_r <= {alu_CarryOut, alu_Result[WIDTH-1:1]};
                        lo_r <= {alu_Result[0], lo_r[WIDTH-1:1]};
                    end else begin
                        hi_r <= {1'b0, hi_r[WIDTH-1:1]};
                        lo_r <= {hi_r[0], lo_r[WIDTH-1:1]};
                    end
                    if (counter == LAST_ITER) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Self-checking bench for muldiv_seq. Provides a behavioural ALU, a
// cycle-level reference model of the request/response timing with results
// computed by plain arithmetic, a per-cycle compare process, directed cases
// with hand-computed results, and a randomized operation sequence.
module tb_muldiv_seq;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;

    logic        clk;
    logic        rst;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_ALUop;
    logic [31:0] alu_Result;
    logic        alu_CarryOut;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_ALUop    (alu_ALUop),
        .alu_Result   (alu_Result),
        .alu_CarryOut (alu_CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU living outside the sequencer.
    always_comb begin
        alu_Result   = '0;
        alu_CarryOut = 1'b0;
        case (alu_ALUop)
            ALU_ADD: {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
            ALU_SUB: begin
                alu_Result   = alu_A - alu_B;
                alu_CarryOut = (alu_A < alu_B);
            end
            default: ;
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected {hi, lo} straight from unsigned arithmetic.
    function automatic logic [63:0] reference(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op)
            return {32'd0, a} * {32'd0, b};
        else if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        else
            return {a % b, a / b};
    endfunction

    // Timing model: phase 0 = idle, 1..32 = computing, 33 = result cycle.
    bit          m_ready = 0;
    int          m_phase = 0;
    bit          m_valid = 0;
    bit          m_op    = 0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1;
            m_phase = 0;
            m_valid = 1;
            m_hi    = '0;
            m_lo    = '0;
        end else if (m_ready) begin
            if (m_phase == 0) begin
                if (bus.start) begin
                    m_op          = bus.op;
                    m_a           = bus.src_a;
                    m_b           = bus.src_b;
                    {m_hi, m_lo}  = reference(bus.op, bus.src_a, bus.src_b);
                    m_valid       = 0;
                    m_phase       = 1;
                end
            end else if (m_phase == 33) begin
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == 33) m_valid = 1;
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("busy", bus.busy, (m_phase >= 1 && m_phase <= 33));
            checkOutput("done", bus.done, (m_phase == 33));
            if (m_phase == 0 || m_phase == 33) begin
                checkOutput("alu_op_idle", alu_ALUop, ALU_ADD);
                checkOutput("alu_a_idle", alu_A, 0);
                checkOutput("alu_b_idle", alu_B, 0);
            end else begin
                checkOutput("alu_op_run", alu_ALUop, m_op ? ALU_SUB : ALU_ADD);
                checkOutput("alu_b_run", alu_B, m_op ? m_b : m_a);
            end
            if (m_phase == 33 || (m_phase == 0 && m_valid)) begin
                checkOutput("hi", bus.hi, m_hi);
                checkOutput("lo", bus.lo, m_lo);
            end
        end
    end

    // Present a request so that it is sampled on the next rising edge.
    task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    // Count mid-cycle samples until done, bounded.
    task automatic waitDone(output int cycles, output int busy_cycles);
        bit got;
        got         = 0;
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
            if (bus.done) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within 40 cycles, required done=1");
        end
    endtask

    task automatic runOp(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int bcyc;
        applyStimulus(op, a, b);
        waitDone(cyc, bcyc);
        checkOutput({name, "_hi"}, bus.hi, exp_hi);
        checkOutput({name, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int          cyc;
        int          bcyc;
        bit          done_seen;
        logic        r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_hi", bus.hi, 0);
        checkOutput("reset_lo", bus.lo, 0);
        checkOutput("reset_aluop", alu_ALUop, ALU_ADD);

        // Pin the reference model itself with hand-computed values.
        checkOutput("model_mul", reference(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        checkOutput("model_div", reference(1'b1, 32'h8000_0000, 32'd3), {32'd2, 32'h2AAA_AAAA});
        checkOutput("model_div0", reference(1'b1, 32'd12345, 32'd0), {32'd12345, 32'hFFFF_FFFF});

        // Largest product, with latency and busy width.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(cyc, bcyc);
        checkOutput("mul_max_latency", cyc, 33);
        checkOutput("mul_max_busy_cycles", bcyc, 33);
        checkOutput("mul_max_hi", bus.hi, 32'hFFFF_FFFE);
        checkOutput("mul_max_lo", bus.lo, 32'h0000_0001);

        // Divides, issued back to back.
        runOp("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("div_msb", 1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);
        runOp("div_by_zero", 1'b1, 32'd12345, 32'd0, 32'd12345, 32'hFFFF_FFFF);
        runOp("div_small", 1'b1, 32'd5, 32'd9, 32'd5, 32'd0);

        // A start during RUN must be ignored.
        applyStimulus(1'b1, 32'd1000, 32'd10);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.src_a = 32'd77;
        bus.src_b = 32'd99;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        waitDone(cyc, bcyc);
        checkOutput("ignored_start_hi", bus.hi, 32'd0);
        checkOutput("ignored_start_lo", bus.lo, 32'd100);
        // Start presented in the idle cycle right after done is accepted.
        runOp("back_to_back", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        // Reset in the middle of a run discards the partial result.
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_hi", bus.hi, 0);
        checkOutput("midrst_lo", bus.lo, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1;
        end
        checkOutput("midrst_no_done", done_seen, 0);
        runOp("after_rst_mul", 1'b0, 32'd1234, 32'd5678, 32'd0, 32'd7006652);

        // Randomized operations, checked by the compare process.
        for (int n = 0; n < 24; n++) begin
            r_op = 1'($urandom_range(0, 1));
            r_a  = $urandom;
            case ($urandom_range(0, 4))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 255);
                2:       r_b = r_a;
                3:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) r_a = $urandom_range(0, 1000);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus(r_op, r_a, r_b);
            waitDone(cyc, bcyc);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer performing 32x32 unsigned multiply (MULTU) and unsigned divide (DIVU) by driving one shared combinational ALU instance iteratively.
- The ALU is instantiated outside this block; this block owns its inputs while busy.
- Sits beside the EX stage of the MIPS core; the core stalls while busy=1 and reads hi/lo when done=1.
- Shift-add multiply and restoring divide; one ALU operation per cycle.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; it fixes the iteration count.
- ITER, 32, iterations per operation. Must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = MULTU, 1 = DIVU; sampled with start.
- src_a  in  32  multiplicand / dividend; sampled with start.
- src_b  in  32  multiplier / divisor; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- hi  out  32  MULTU: product[63:32]; DIVU: remainder.
- lo  out  32  MULTU: product[31:0]; DIVU: quotient.
- alu_A  out  32  to ALU A.
- alu_B  out  32  to ALU B.
- alu_ALUop  out  4  to ALU ALUop.
- alu_Result  in  32  from ALU Result.
- alu_CarryOut  in  1  from ALU CarryOut: carry on ADD, borrow (A<B unsigned) on SUB.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal operand regs=0. Reset overrides all other activity, including mid-RUN; a partial result is discarded and not flagged done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs alu_A=0, alu_B=0, alu_ALUop=4'b0010 (ADD).
  - On start=1: latch op, src_a, src_b; set counter=0; go to RUN.
  - Clear hi/lo working regs at this point: MULTU acc=0, lo=src_b; DIVU rem=0, lo=src_a.
- RUN, MULTU, each cycle:
  - Drive alu_A=hi, alu_B=multiplicand, ALUop=4'b0010.
  - If lo[0]=1: {c,hi,lo} <= {alu_CarryOut, alu_Result, lo} >> 1.
  - Else: {hi,lo} <= {1'b0, hi, lo} >> 1.
- RUN, DIVU, each cycle:
  - Form shifted remainder s = {hi[30:0], lo[31]}, with msb_out = hi[31].
  - Drive alu_A=s, alu_B=divisor, ALUop=4'b1010 (SUB).
  - Quotient bit q = msb_out | ~alu_CarryOut.
  - hi <= q ? alu_Result : s; lo <= {lo[30:0], q}.
- RUN exit: counter increments each RUN cycle; after the cycle with counter=31, go to DONE.
- DONE: done=1 for exactly one cycle, ALU outputs as in IDLE, then go to IDLE.
- Latency: start sampled at edge N → done=1 in the cycle after edge N+32 (33 cycles start-to-done). Back-to-back: next start is accepted at the first IDLE cycle, i.e. 34-cycle issue interval.
- Result hold: hi/lo hold final values from DONE until the next accepted start or reset; they are not valid during RUN.
- Simultaneous events:
  - start while busy=1 is ignored, with no queueing.
  - start and rst in the same cycle: rst wins.
- Divide by zero is not trapped. The algorithm yields lo=32'hFFFFFFFF, hi=src_a.
- Operand edge cases need no special handling: 0 operands, 32'hFFFFFFFF operands, and dividend < divisor all fall out of the algorithm.

Test Plan:
- Reset then idle: hold rst 2 cycles → busy=0, done=0, hi=0, lo=0, alu_ALUop=4'b0010.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → done exactly 33 cycles after start; hi=32'hFFFFFFFE, lo=32'h00000001; busy high 33 cycles.
- DIVU 100 ÷ 7 → lo=14, hi=2. DIVU 32'h80000000 ÷ 3 → lo=32'h2AAAAAAA, hi=2 (checks the msb_out path).
- DIVU 12345 ÷ 0 → lo=32'hFFFFFFFF, hi=12345. DIVU 5 ÷ 9 → lo=0, hi=5.
- start pulsed at cycle 10 of RUN with different operands → ignored; first result unchanged. A second start in the IDLE cycle right after done → accepted.
- rst asserted mid-RUN (cycle 15) → next cycle IDLE, hi=lo=0, no done pulse. A fresh MULTU 1234 × 5678 then yields hi=0, lo=7006652.
